alu_seq: RTL and testbench

- Parametrised, registered successor to the combinational Jac1-8 ALU.
- Accepts one operation per start strobe and latches opcode and operands.
- Produces a registered result and status with a done pulse.
- Adds SUB, multi-cycle SHL/SHR by a param-given amount, VAL pass-through, and Zero computed from the new result. Sits between the register file and the writeback/flow-control logic of the core.

---
 rtl/alu_seq.sv | 163 ++++++++++++++++
 tb/tb_alu_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a multi-cycle barrel-free shifter.
//
// One operation is accepted per start strobe while idle. Single-cycle ops
// (and shifts by zero) write result/status on the start edge and pulse done
// for that cycle. SHL/SHR by n>0 shift one bit per edge and finish n edges
// after the start edge.
//
// Handshake: start is sampled only on edges where busy=0; a start seen while
// busy=1 is dropped (no queuing). done is a one-cycle pulse marking the cycle
// in which result/status hold a fresh value. A start in a done cycle is
// accepted like any other idle-cycle start.
//
// Ports:
//   clock    - system clock, rising edge
//   reset    - synchronous active-high reset
//   start    - operation request
//   opcode   - operation select
//   operand1 - first operand / shift source
//   operand2 - second operand / NOT source
//   param    - shift amount (SHL/SHR) or immediate (VAL)
//   busy     - shift in progress
//   done     - result/status updated this cycle
//   result   - registered result, held until next done
//   status   - {zero, underflow, carry}, held until next done
module alu_seq #(
  parameter int DataWidth     = 8,
  parameter int NumOpCodeBits = 5,
  parameter int ParamBits     = 8,
  parameter int NumStatusBits = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NumOpCodeBits-1:0] opcode,
  input  logic [DataWidth-1:0]     operand1,
  input  logic [DataWidth-1:0]     operand2,
  input  logic [ParamBits-1:0]     param,
  output logic                     busy,
  output logic                     done,
  output logic [DataWidth-1:0]     result,
  output logic [NumStatusBits-1:0] status
);

  localparam int CW = $clog2(DataWidth + 1);

  localparam logic [NumOpCodeBits-1:0] OP_ADD = NumOpCodeBits'(1);
  localparam logic [NumOpCodeBits-1:0] OP_SUB = NumOpCodeBits'(2);
  localparam logic [NumOpCodeBits-1:0] OP_AND = NumOpCodeBits'(3);
  localparam logic [NumOpCodeBits-1:0] OP_OR  = NumOpCodeBits'(4);
  localparam logic [NumOpCodeBits-1:0] OP_NOT = NumOpCodeBits'(5);
  localparam logic [NumOpCodeBits-1:0] OP_XOR = NumOpCodeBits'(6);
  localparam logic [NumOpCodeBits-1:0] OP_SHL = NumOpCodeBits'(7);
  localparam logic [NumOpCodeBits-1:0] OP_SHR = NumOpCodeBits'(8);
  localparam logic [NumOpCodeBits-1:0] OP_VAL = NumOpCodeBits'(9);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state;
  logic [DataWidth-1:0] sh_q;      // working copy of the value being shifted
  logic [CW-1:0]        cnt_q;     // shifts still to perform
  logic                 left_q;    // 1 = SHL, 0 = SHR

  // Single-cycle datapath, driven straight from the inputs on the start edge.
  logic [DataWidth:0]   sum;
  logic [DataWidth-1:0] imm_res;
  logic                 imm_c;
  logic                 imm_u;
  logic                 imm_z;
  logic                 is_shift;
  logic [CW-1:0]        n_calc;

  // One shift step of the multi-cycle path.
  logic [DataWidth-1:0] sh_next;
  logic                 sh_c;

  assign busy = (state == SHIFT);

  always_comb begin
    sum      = {1'b0, operand1} + {1'b0, operand2};
    imm_res  = '0;
    imm_c    = 1'b0;
    imm_u    = 1'b0;
    imm_z    = 1'b0;
    is_shift = (opcode == OP_SHL) || (opcode == OP_SHR);
    // Amounts at or beyond the width saturate: every bit gets shifted out.
    if (32'(param) < DataWidth) n_calc = CW'(param);
    else                        n_calc = CW'(DataWidth);

    case (opcode)
      OP_ADD: begin
        imm_res = sum[DataWidth-1:0];
        imm_c   = sum[DataWidth];
      end
      OP_SUB: begin
        imm_res = operand1 - operand2;
        imm_u   = (operand1 < operand2);
      end
      OP_AND: imm_res = operand1 & operand2;
      OP_OR:  imm_res = operand1 | operand2;
      OP_NOT: imm_res = ~operand2;
      OP_XOR: imm_res = operand1 ^ operand2;
      OP_SHL, OP_SHR: imm_res = operand1;  // only reached with n = 0
      OP_VAL: imm_res = DataWidth'(param);
      default: imm_res = '0;
    endcase

    // NOP/reserved/flow-control opcodes report a clear status, zero included.
    if (opcode >= OP_ADD && opcode <= OP_VAL) imm_z = (imm_res == '0);
  end

  always_comb begin
    if (left_q) begin
      sh_next = {sh_q[DataWidth-2:0], 1'b0};
      sh_c    = sh_q[DataWidth-1];
    end else begin
      sh_next = {1'b0, sh_q[DataWidth-1:1]};
      sh_c    = sh_q[0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      sh_q   <= '0;
      cnt_q  <= '0;
      left_q <= 1'b0;
      result <= '0;
      status <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_shift && n_calc != '0) begin
              state  <= SHIFT;
              sh_q   <= operand1;
              cnt_q  <= n_calc;
              left_q <= (opcode == OP_SHL);
            end else begin
              result <= imm_res;
              status <= {imm_z, imm_u, imm_c};
              done   <= 1'b1;
            end
          end
        end
        SHIFT: begin
          sh_q  <= sh_next;
          cnt_q <= cnt_q - CW'(1);
          // Carry is the bit dropped on the final step only.
          if (cnt_q == CW'(1)) begin
            result <= sh_next;
            status <= {(sh_next == '0), 1'b0, sh_c};
            done   <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (DataWidth=8): each step drives a vector,
// advances the clock and checks outputs 1 time unit after the rising edge
// against hand-computed values.
module tb_alu_seq;

  logic       clock;
  logic       reset;
  logic       start;
  logic [4:0] opcode;
  logic [7:0] operand1;
  logic [7:0] operand2;
  logic [7:0] param;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [2:0] status;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [4:0] NOP = 5'b00000, ADD = 5'b00001, SUB = 5'b00010,
                         ANDO = 5'b00011, ORO = 5'b00100, NOTO = 5'b00101,
                         XORO = 5'b00110, SHL = 5'b00111, SHR = 5'b01000,
                         VAL = 5'b01001;

  alu_seq dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .opcode   (opcode),
    .operand1 (operand1),
    .operand2 (operand2),
    .param    (param),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .status   (status)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] p);
    opcode   = op;
    operand1 = a;
    operand2 = b;
    param    = p;
    start    = 1'b1;
  endtask

  // Single-edge operation: done, result and status on the start edge.
  task automatic op_imm(input string tag, input logic [4:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] p,
                        input logic [7:0] exp_r, input logic [2:0] exp_s);
    drive(op, a, b, p);
    step();
    start = 1'b0;
    chk({tag, ".done"},   32'(done),   32'd1);
    chk({tag, ".busy"},   32'(busy),   32'd0);
    chk({tag, ".result"}, 32'(result), 32'(exp_r));
    chk({tag, ".status"}, 32'(status), 32'(exp_s));
  endtask

  // Multi-cycle shift: busy for n cycles, done on the n-th edge after start.
  task automatic op_shift(input string tag, input logic [4:0] op, input logic [7:0] a,
                          input logic [7:0] p, input int n,
                          input logic [7:0] exp_r, input logic [2:0] exp_s);
    drive(op, a, 8'h00, p);
    step();
    start = 1'b0;
    opcode = NOP;
    operand1 = 8'hxx;
    for (int i = 1; i < n; i++) begin
      chk({tag, ".busy_mid"}, 32'(busy), 32'd1);
      chk({tag, ".done_mid"}, 32'(done), 32'd0);
      step();
    end
    chk({tag, ".busy_last"}, 32'(busy), 32'd1);
    step();
    chk({tag, ".done"},   32'(done),   32'd1);
    chk({tag, ".busy"},   32'(busy),   32'd0);
    chk({tag, ".result"}, 32'(result), 32'(exp_r));
    chk({tag, ".status"}, 32'(status), 32'(exp_s));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; opcode = NOP;
    operand1 = 8'h00; operand2 = 8'h00; param = 8'h00;
    step();
    step();
    chk("rst.result", 32'(result), 32'd0);
    chk("rst.status", 32'(status), 32'd0);
    chk("rst.busy",   32'(busy),   32'd0);
    chk("rst.done",   32'(done),   32'd0);
    reset = 1'b0;
    step();
    chk("idle.done", 32'(done), 32'd0);

    // 1: ADD, back-to-back in the done cycle
    op_imm("add_ovf",  ADD, 8'd200, 8'd100, 8'h00, 8'd44,  3'b001);
    op_imm("add_zero", ADD, 8'd0,   8'd0,   8'h00, 8'd0,   3'b100);
    op_imm("add_plain", ADD, 8'h0F, 8'h01,  8'h00, 8'h10,  3'b000);
    step();
    chk("add.done_pulse", 32'(done), 32'd0);
    chk("add.hold",       32'(result), 32'h10);

    // 2: SUB
    op_imm("sub_neg",  SUB, 8'd5, 8'd7, 8'h00, 8'd254, 3'b010);
    op_imm("sub_zero", SUB, 8'd9, 8'd9, 8'h00, 8'd0,   3'b100);

    // Logic ops
    op_imm("and", ANDO, 8'hF0, 8'h3C, 8'h00, 8'h30, 3'b000);
    op_imm("or",  ORO,  8'hF0, 8'h0C, 8'h00, 8'hFC, 3'b000);
    op_imm("xor", XORO, 8'hF0, 8'h0F, 8'h00, 8'hFF, 3'b000);
    op_imm("not", NOTO, 8'h12, 8'hFF, 8'h00, 8'h00, 3'b100);

    // 3: shifts
    op_shift("shl1",   SHL, 8'h81, 8'd1,   1, 8'h02, 3'b001);
    op_shift("shr8",   SHR, 8'h80, 8'd8,   8, 8'h00, 3'b101);
    op_shift("shr200", SHR, 8'h80, 8'd200, 8, 8'h00, 3'b101);
    op_shift("shr3",   SHR, 8'h0D, 8'd3,   3, 8'h01, 3'b001);

    // 4: shift by zero, VAL, reserved opcodes
    op_imm("shl0",  SHL, 8'h55, 8'h00, 8'h00, 8'h55, 3'b000);
    op_imm("val",   VAL, 8'hAA, 8'hAA, 8'h3C, 8'h3C, 3'b000);
    op_imm("val0",  VAL, 8'hAA, 8'hAA, 8'h00, 8'h00, 3'b100);
    op_imm("nop",   NOP, 8'h11, 8'h22, 8'h33, 8'h00, 3'b000);
    op_imm("rsv",   5'b10011, 8'h11, 8'h22, 8'h33, 8'h00, 3'b000);
    op_imm("rsv2",  5'b01010, 8'h11, 8'h22, 8'h33, 8'h00, 3'b000);

    // 5: start ignored while busy; start in done cycle accepted
    drive(SHR, 8'hB0, 8'h00, 8'd5);
    step();                                   // start edge
    start = 1'b0;
    chk("busy5.busy", 32'(busy), 32'd1);
    step();                                   // edge +1
    drive(ADD, 8'd1, 8'd1, 8'h00);
    step();                                   // edge +2, start ignored
    start = 1'b0;
    chk("busy5.ign_done", 32'(done), 32'd0);
    chk("busy5.ign_busy", 32'(busy), 32'd1);
    step();                                   // edge +3
    chk("busy5.e3_done", 32'(done), 32'd0);
    step();                                   // edge +4
    chk("busy5.e4_done", 32'(done), 32'd0);
    step();                                   // edge +5
    chk("busy5.done",   32'(done),   32'd1);
    chk("busy5.busy0",  32'(busy),   32'd0);
    chk("busy5.result", 32'(result), 32'h05);
    chk("busy5.status", 32'(status), 32'b001);
    op_imm("add_on_done", ADD, 8'd3, 8'd4, 8'h00, 8'd7, 3'b000);
    step();
    chk("post.done", 32'(done), 32'd0);
    chk("post.hold", 32'(result), 32'd7);

    // 6: reset mid-shift
    drive(SHL, 8'h01, 8'h00, 8'd6);
    step();                                   // start edge
    start = 1'b0;
    step();
    chk("rstmid.hold", 32'(result), 32'd7);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstmid.busy",   32'(busy),   32'd0);
    chk("rstmid.done",   32'(done),   32'd0);
    chk("rstmid.result", 32'(result), 32'd0);
    chk("rstmid.status", 32'(status), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rstmid.no_done", 32'(done), 32'd0);
    end
    op_shift("shl7", SHL, 8'h03, 8'd7, 7, 8'h80, 3'b001);

    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
